// File: rtl/if_id_imm_stage_pkg.sv
// Shared definitions for the fetch-to-decode stage: opcodes, NOP, stage states.
package if_id_imm_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IMM_W = 12;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

endpackage

// File: rtl/if_id_imm_stage_imm12_extract.sv
// Raw 12-bit immediate extraction (I/S/B formats) for the 12->32 sign extender.
module if_id_imm_stage_imm12_extract
    import if_id_imm_stage_pkg::*;
(
    input  logic [31:0] instr,
    output logic [11:0] imm12
);

    // rs1/funct3 field never contributes to a 12-bit immediate
    logic unused_bits;
    assign unused_bits = ^instr[19:12];

    // Select immediate layout by opcode; B-type drops the implied bit 0
    always_comb begin
        imm12 = 12'd0;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: imm12 = instr[31:20];
            OP_STORE:  imm12 = {instr[31:25], instr[11:7]};
            OP_BRANCH: imm12 = {instr[31], instr[7], instr[30:25], instr[11:8]};
            default:   imm12 = 12'd0;
        endcase
    end

endmodule

// File: rtl/if_id_imm_stage.sv
// IF/ID pipeline register: 2-entry skid buffer of {PC, instr, imm12} with
// valid/ready handshake, flush and registered In_ready.
// Optional stall counter enabled by defining IF_ID_STALL_COUNT_EN.
module if_id_imm_stage #(
    parameter int unsigned           XLEN      = if_id_imm_stage_pkg::XLEN,
    parameter int unsigned           IMM_W     = if_id_imm_stage_pkg::IMM_W,
    parameter logic [XLEN-1:0]       NOP_INSTR = if_id_imm_stage_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [XLEN-1:0]  PC_in,
    input  logic [XLEN-1:0]  Instr_in,
    input  logic             Flush,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [XLEN-1:0]  PC_out,
    output logic [XLEN-1:0]  Instr_out,
    output logic [IMM_W-1:0] Imm12,
    output logic [15:0]      Stall_count
);
    import if_id_imm_stage_pkg::*;

    stage_state_e     state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  head_pc_q, head_pc_d;
    logic [XLEN-1:0]  head_instr_q, head_instr_d;
    logic [IMM_W-1:0] head_imm_q, head_imm_d;
    logic [XLEN-1:0]  skid_pc_q, skid_pc_d;
    logic [XLEN-1:0]  skid_instr_q, skid_instr_d;
    logic [IMM_W-1:0] skid_imm_q, skid_imm_d;

    logic [11:0]      in_imm12;
    logic [IMM_W-1:0] in_imm;
    logic             xfer_in;
    logic             xfer_out;

    if_id_imm_stage_imm12_extract u_imm12_extract (
        .instr (Instr_in[31:0]),
        .imm12 (in_imm12)
    );

    assign in_imm   = IMM_W'(in_imm12);
    assign xfer_in  = In_valid && in_ready_q;
    assign xfer_out = out_valid_q && Out_ready;

    // State and entry registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            head_pc_q    <= '0;
            head_instr_q <= NOP_INSTR;
            head_imm_q   <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_imm_q   <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            head_imm_q   <= head_imm_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_imm_q   <= skid_imm_d;
        end
    end

    // Next state, entry movement and registered handshake outputs
    always_comb begin
        state_d      = state_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        head_imm_d   = head_imm_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        skid_imm_d   = skid_imm_q;

        if (Flush) begin
            // PC_out keeps its last value while empty
            state_d      = EMPTY;
            head_instr_d = NOP_INSTR;
            head_imm_d   = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (xfer_in) begin
                        state_d      = ONE;
                        head_pc_d    = PC_in;
                        head_instr_d = Instr_in;
                        head_imm_d   = in_imm;
                    end
                end
                ONE: begin
                    if (xfer_in && xfer_out) begin
                        head_pc_d    = PC_in;
                        head_instr_d = Instr_in;
                        head_imm_d   = in_imm;
                    end else if (xfer_in) begin
                        state_d      = TWO;
                        skid_pc_d    = PC_in;
                        skid_instr_d = Instr_in;
                        skid_imm_d   = in_imm;
                    end else if (xfer_out) begin
                        state_d      = EMPTY;
                        head_instr_d = NOP_INSTR;
                        head_imm_d   = '0;
                    end
                end
                TWO: begin
                    // In_ready is low here, so only the drain path exists
                    if (xfer_out) begin
                        state_d      = ONE;
                        head_pc_d    = skid_pc_q;
                        head_instr_d = skid_instr_q;
                        head_imm_d   = skid_imm_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != TWO);
    end

    assign In_ready  = in_ready_q;
    assign Out_valid = out_valid_q;
    assign PC_out    = head_pc_q;
    assign Instr_out = head_instr_q;
    assign Imm12     = head_imm_q;

`ifdef IF_ID_STALL_COUNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles where a valid head is held by decode
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
        end else if (out_valid_q && !Out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign Stall_count = stall_cnt_q;
`else
    assign Stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_if_id_imm_stage.sv
// Scoreboard bench for if_id_imm_stage (honours IF_ID_STALL_COUNT_EN).
module tb_if_id_imm_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        In_valid;
    logic        In_ready;
    logic [31:0] PC_in;
    logic [31:0] Instr_in;
    logic        Flush;
    logic        Out_valid;
    logic        Out_ready;
    logic [31:0] PC_out;
    logic [31:0] Instr_out;
    logic [11:0] Imm12;
    logic [15:0] Stall_count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [11:0] imm;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_stall;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          last_in_x;

    if_id_imm_stage dut (
        .clk         (clk),
        .reset       (reset),
        .In_valid    (In_valid),
        .In_ready    (In_ready),
        .PC_in       (PC_in),
        .Instr_in    (Instr_in),
        .Flush       (Flush),
        .Out_valid   (Out_valid),
        .Out_ready   (Out_ready),
        .PC_out      (PC_out),
        .Instr_out   (Instr_out),
        .Imm12       (Imm12),
        .Stall_count (Stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_imm(input logic [31:0] i);
        logic [6:0] op;
        op = i[6:0];
        if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73) return i[31:20];
        if (op == 7'h23) return {i[31:25], i[11:7]};
        if (op == 7'h63) return {i[31], i[7], i[30:25], i[11:8]};
        return 12'h000;
    endfunction

    // Update the model from the inputs/handshake seen before the edge, then clock
    task automatic cycle();
        bit   in_x;
        bit   out_x;
        exp_t e;
        in_x  = In_valid && In_ready && !reset && !Flush;
        out_x = Out_valid && Out_ready && !reset && !Flush;
        if (reset) begin
            sb.delete();
            exp_stall = 16'd0;
        end else begin
`ifdef IF_ID_STALL_COUNT_EN
            if (sb.size() != 0 && !Out_ready && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
`endif
            if (Flush) begin
                sb.delete();
            end else begin
                if (out_x && sb.size() != 0) begin
                    e = sb.pop_front();
                    check("pop_pc", PC_out, e.pc);
                    check("pop_instr", Instr_out, e.instr);
                    check("pop_imm", 32'(Imm12), 32'(e.imm));
                end
                if (in_x) begin
                    e.pc    = PC_in;
                    e.instr = Instr_in;
                    e.imm   = ref_imm(Instr_in);
                    sb.push_back(e);
                end
            end
        end
        last_in_x = in_x;
        @(posedge clk);
        #1;
        check("out_valid", 32'(Out_valid), 32'(sb.size() != 0));
        check("in_ready", 32'(In_ready), 32'(sb.size() < 2));
        check("stall_count", 32'(Stall_count), 32'(exp_stall));
        if (sb.size() == 0) begin
            check("empty_instr", Instr_out, NOP);
            check("empty_imm", 32'(Imm12), 32'd0);
        end
    endtask

    // Offer one word until accepted, bounded
    task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
        In_valid = 1'b1;
        PC_in    = pc;
        Instr_in = instr;
        last_in_x = 1'b0;
        for (int k = 0; k < 20 && !last_in_x; k++) cycle();
        if (!last_in_x) begin
            n_cmp++;
            n_err++;
            $display("FAIL offer_timeout: pc %h never accepted", pc);
        end
        In_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 32'(Out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(In_ready), 32'd1);
        check({tag, "_pc"}, PC_out, 32'd0);
        check({tag, "_instr"}, Instr_out, NOP);
        check({tag, "_imm"}, 32'(Imm12), 32'd0);
        check({tag, "_stall"}, 32'(Stall_count), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        In_valid  = 1'b0;
        PC_in     = '0;
        Instr_in  = '0;
        Flush     = 1'b0;
        Out_ready = 1'b0;
        exp_stall = 16'd0;

        cycle();
        cycle();
        reset = 1'b0;
        check_reset_values("reset");
        cycle();

        // Flow-through with decode always ready
        Out_ready = 1'b1;
        offer(32'h0000_0000, 32'h0050_0093);
        check("addi_valid", 32'(Out_valid), 32'd1);
        check("addi_instr", Instr_out, 32'h0050_0093);
        check("addi_imm", 32'(Imm12), 32'h005);
        offer(32'h0000_0004, 32'hFE20_AE23);
        check("sw_imm", 32'(Imm12), 32'hFFC);
        offer(32'h0000_0008, 32'h0000_10B7);
        check("lui_imm", 32'(Imm12), 32'h000);
        offer(32'h0000_000C, 32'hFE00_0EE3);
        check("beq_imm", 32'(Imm12), 32'hFFE);
        offer(32'h0000_0010, 32'h0081_2183);
        check("lw_imm", 32'(Imm12), 32'h008);
        cycle();

        // Stall: two words fill the buffer, third is held upstream
        Out_ready = 1'b0;
        offer(32'h0000_0100, 32'h0010_0113);
        offer(32'h0000_0104, 32'h0030_2023);
        check("full_in_ready", 32'(In_ready), 32'd0);
        In_valid = 1'b1;
        PC_in    = 32'h0000_0108;
        Instr_in = 32'h0020_8663;
        for (int k = 0; k < 3; k++) cycle();
        check("held_in_ready", 32'(In_ready), 32'd0);
        check("held_head_pc", PC_out, 32'h0000_0100);
`ifdef IF_ID_STALL_COUNT_EN
        check("stall_total", 32'(Stall_count), 32'd4);
`endif
        Out_ready = 1'b1;
        offer(32'h0000_0108, 32'h0020_8663);
        for (int k = 0; k < 4; k++) cycle();
        check("drained", 32'(Out_valid), 32'd0);

        // Flush in TWO with a word offered
        Out_ready = 1'b0;
        offer(32'h0000_0200, 32'h0070_0293);
        offer(32'h0000_0204, 32'h0090_0313);
        In_valid = 1'b1;
        PC_in    = 32'h0000_0208;
        Instr_in = 32'h00B0_0393;
        Flush    = 1'b1;
        cycle();
        Flush    = 1'b0;
        In_valid = 1'b0;
        check("flush2_valid", 32'(Out_valid), 32'd0);
        check("flush2_ready", 32'(In_ready), 32'd1);
        check("flush2_instr", Instr_out, NOP);
        Out_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();

        // Flush in ONE while In_ready is high: offered word dropped
        Out_ready = 1'b0;
        offer(32'h0000_0300, 32'h0050_0413);
        In_valid = 1'b1;
        PC_in    = 32'h0000_0304;
        Instr_in = 32'h0060_0493;
        Flush    = 1'b1;
        cycle();
        Flush    = 1'b0;
        In_valid = 1'b0;
        check("flush1_valid", 32'(Out_valid), 32'd0);
        check("flush1_imm", 32'(Imm12), 32'd0);
        Out_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();

        // Reset while full and stalled
        Out_ready = 1'b0;
        offer(32'h0000_0400, 32'h0010_0513);
        offer(32'h0000_0404, 32'h0020_0593);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_reset_values("reset2");

        // Operation resumes after reset
        Out_ready = 1'b1;
        offer(32'h0000_0500, 32'hFFF0_0613);
        check("post_imm", 32'(Imm12), 32'hFFF);
        for (int k = 0; k < 2; k++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
